// File: rtl/pixie_dma_server.sv
// pixie_dma_server: port-B owner of the shared program/display dpram.
// Serves CDP1861 display-DMA byte reads (vid_rd -> vid_ack) and
// ROM/cartridge download writes. A write that arrives during a video read
// is parked in a one-entry hold register and issued after the ack.
// Optional feature macro: PIXIE_DMA_OVERRUN_EN. When it is defined,
// ovr_cnt counts dropped video requests. When it is not defined,
// ovr_cnt is tied to zero.
module pixie_dma_server #(
  parameter int unsigned       ADDR_W    = 12,
  parameter logic [ADDR_W-1:0] VRAM_BASE = 12'h900,
  parameter logic [ADDR_W-1:0] CART_BASE = 12'h400,
  parameter int unsigned       LAT       = 1
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic              vid_rd,
  input  logic [9:0]        vid_addr,
  output logic [7:0]        vid_data,
  output logic              vid_ack,
  output logic              mem_ce,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  input  logic [7:0]        mem_dout,
  output logic              busy,
  output logic [7:0]        ovr_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_DL_WR, S_VID_RD, S_VID_WAIT, S_VID_ACK
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              zpend_q, zpend_d;
  logic              hold_v_q, hold_v_d;
  logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
  logic [7:0]        hold_din_q, hold_din_d;
  logic [7:0]        vid_data_q, vid_data_d;
  logic              vid_ack_q, vid_ack_d;
  logic              mem_ce_q, mem_ce_d;
  logic              mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_din_q, mem_din_d;
  logic              busy_q, busy_d;

  logic              dl_wr_in;
  logic              vid_active;
  logic              ovr_hit;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic              unused_addr_bits;

  assign dl_wr_in         = ioctl_download & ioctl_wr;
  assign vid_active       = (state_q == S_VID_RD) || (state_q == S_VID_WAIT) ||
                            (state_q == S_VID_ACK);
  // A second request while one is outstanding (real or zero-ack) is dropped.
  assign ovr_hit          = vid_rd & (vid_active | zpend_q);
  assign wr_addr          = (ioctl_index == 8'd0) ? ioctl_addr[ADDR_W-1:0]
                                                  : CART_BASE + ioctl_addr[ADDR_W-1:0];
  assign rd_addr          = VRAM_BASE + ADDR_W'(vid_addr);
  assign unused_addr_bits = ^ioctl_addr[24:ADDR_W];

  // Next-state and next-output computation for the port-B arbiter FSM.
  always_comb begin
    // NOTE: every *_d gets a default here so no path leaves it unassigned (no latches).
    state_d     = state_q;
    cnt_d       = cnt_q;
    zpend_d     = vid_rd & ioctl_download & ~ovr_hit;
    hold_v_d    = hold_v_q;
    hold_addr_d = hold_addr_q;
    hold_din_d  = hold_din_q;
    vid_ack_d   = zpend_q;
    vid_data_d  = zpend_q ? 8'h00 : vid_data_q;
    mem_ce_d    = 1'b0;
    mem_wr_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;

    unique case (state_q)
      S_IDLE, S_DL_WR: begin
        if (dl_wr_in) begin
          state_d    = S_DL_WR;
          mem_ce_d   = 1'b1;
          mem_wr_d   = 1'b1;
          mem_addr_d = wr_addr;
          mem_din_d  = ioctl_dout;
        end else if (vid_rd && !ioctl_download && !ovr_hit) begin
          state_d    = S_VID_RD;
          mem_ce_d   = 1'b1;
          mem_addr_d = rd_addr;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_VID_RD, S_VID_WAIT: begin
        if (dl_wr_in && !hold_v_q) begin
          hold_v_d    = 1'b1;
          hold_addr_d = wr_addr;
          hold_din_d  = ioctl_dout;
        end
        if (state_q == S_VID_RD) begin
          state_d = S_VID_WAIT;
          cnt_d   = 2'(LAT - 1);
        end else if (cnt_q == 2'd0) begin
          state_d    = S_VID_ACK;
          vid_ack_d  = 1'b1;
          vid_data_d = mem_dout;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_VID_ACK: begin
        if (hold_v_q) begin
          state_d    = S_DL_WR;
          hold_v_d   = 1'b0;
          mem_ce_d   = 1'b1;
          mem_wr_d   = 1'b1;
          mem_addr_d = hold_addr_q;
          mem_din_d  = hold_din_q;
        end else if (dl_wr_in) begin
          state_d    = S_DL_WR;
          mem_ce_d   = 1'b1;
          mem_wr_d   = 1'b1;
          mem_addr_d = wr_addr;
          mem_din_d  = ioctl_dout;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and registered-output flops; reset aborts any transaction in flight.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 2'd0;
      zpend_q     <= 1'b0;
      hold_v_q    <= 1'b0;
      hold_addr_q <= '0;
      hold_din_q  <= 8'h00;
      vid_data_q  <= 8'h00;
      vid_ack_q   <= 1'b0;
      mem_ce_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= 8'h00;
      busy_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      zpend_q     <= zpend_d;
      hold_v_q    <= hold_v_d;
      hold_addr_q <= hold_addr_d;
      hold_din_q  <= hold_din_d;
      vid_data_q  <= vid_data_d;
      vid_ack_q   <= vid_ack_d;
      mem_ce_q    <= mem_ce_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      busy_q      <= busy_d;
    end
  end

`ifdef PIXIE_DMA_OVERRUN_EN
  logic [7:0] ovr_q, ovr_d;

  // Saturating count of dropped video requests.
  always_comb begin
    ovr_d = ovr_q;
    if (ovr_hit && (ovr_q != 8'hFF)) ovr_d = ovr_q + 8'd1;
  end

  // Overrun counter flop, cleared only by reset.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) ovr_q <= 8'h00;
    else       ovr_q <= ovr_d;
  end

  assign ovr_cnt = ovr_q;
`else
  assign ovr_cnt = 8'h00;
`endif

  assign vid_data = vid_data_q;
  assign vid_ack  = vid_ack_q;
  assign mem_ce   = mem_ce_q;
  assign mem_wr   = mem_wr_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_pixie_dma_server.sv
// tb_pixie_dma_server: directed bench for pixie_dma_server with a dpram model.
// Expected port-B accesses and vid_ack responses are queued by the stimulus
// and popped by a monitor on the falling edge. A second instance with
// VRAM_BASE=12'hF00 covers address wrap.
module tb_pixie_dma_server;

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [7:0]  din;
    int          cyc;
  } mem_exp_t;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } ack_exp_t;

`ifdef PIXIE_DMA_OVERRUN_EN
  localparam logic [7:0] OVR_EXP = 8'd1;
`else
  localparam logic [7:0] OVR_EXP = 8'd0;
`endif

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download, ioctl_wr, vid_rd;
  logic [7:0]  ioctl_index, ioctl_dout;
  logic [24:0] ioctl_addr;
  logic [9:0]  vid_addr;

  logic [7:0]  vid_data, mem_din, mem_dout, ovr_cnt;
  logic        vid_ack, mem_ce, mem_wr, busy;
  logic [11:0] mem_addr;

  logic [7:0]  w_vid_data, w_mem_din, w_mem_dout, w_ovr_cnt;
  logic        w_vid_ack, w_mem_ce, w_mem_wr, w_busy;
  logic [11:0] w_mem_addr;

  logic [7:0]  ram  [0:4095];
  logic [7:0]  wram [0:4095];

  mem_exp_t mem_q[$];
  ack_exp_t ack_q[$];
  mem_exp_t me;
  ack_exp_t ae;

  int cyc     = 0;
  int n_check = 0;
  int n_fail  = 0;
  int k;

  pixie_dma_server #(.VRAM_BASE(12'h900)) u_dut (
    .clk_sys(clk_sys), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .vid_rd(vid_rd), .vid_addr(vid_addr),
    .vid_data(vid_data), .vid_ack(vid_ack),
    .mem_ce(mem_ce), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout),
    .busy(busy), .ovr_cnt(ovr_cnt)
  );

  pixie_dma_server #(.VRAM_BASE(12'hF00)) u_dut_wrap (
    .clk_sys(clk_sys), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .vid_rd(vid_rd), .vid_addr(vid_addr),
    .vid_data(w_vid_data), .vid_ack(w_vid_ack),
    .mem_ce(w_mem_ce), .mem_wr(w_mem_wr), .mem_addr(w_mem_addr),
    .mem_din(w_mem_din), .mem_dout(w_mem_dout),
    .busy(w_busy), .ovr_cnt(w_ovr_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) cyc <= cyc + 1;

  // Single-cycle-latency dpram port-B models.
  always @(posedge clk_sys) begin
    if (mem_ce && mem_wr)    ram[mem_addr] <= mem_din;
    if (mem_ce && !mem_wr)   mem_dout <= ram[mem_addr];
    if (w_mem_ce && w_mem_wr)  wram[w_mem_addr] <= w_mem_din;
    if (w_mem_ce && !w_mem_wr) w_mem_dout <= wram[w_mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_check++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push_mem(input logic wr, input logic [11:0] a, input logic [7:0] d, input int c);
    mem_exp_t e;
    e.wr = wr; e.addr = a; e.din = d; e.cyc = c;
    mem_q.push_back(e);
  endtask

  task automatic push_ack(input logic [7:0] d, input int c);
    ack_exp_t e;
    e.data = d; e.cyc = c;
    ack_q.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_vid_ack"},  32'(vid_ack),  32'h0);
    check({tag, "_vid_data"}, 32'(vid_data), 32'h0);
    check({tag, "_mem_ce"},   32'(mem_ce),   32'h0);
    check({tag, "_mem_wr"},   32'(mem_wr),   32'h0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'h0);
    check({tag, "_mem_din"},  32'(mem_din),  32'h0);
    check({tag, "_busy"},     32'(busy),     32'h0);
    check({tag, "_ovr_cnt"},  32'(ovr_cnt),  32'h0);
  endtask

  task automatic dl_write(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d,
                          input logic [11:0] exp_addr);
    tick();
    k = cyc;
    ioctl_wr = 1'b1; ioctl_index = idx; ioctl_addr = a; ioctl_dout = d;
    push_mem(1'b1, exp_addr, d, k + 1);
    tick();
    ioctl_wr = 1'b0;
    idle(2);
  endtask

  // Monitor: every port-B access and every ack must match the head of its queue.
  always @(negedge clk_sys) begin
    check("mem_wr_needs_ce", 32'(mem_wr & ~mem_ce), 32'h0);
    if (mem_ce) begin
      if (mem_q.size() == 0) begin
        check("mem_ce_unexpected", 32'(mem_ce), 32'h0);
      end else begin
        me = mem_q.pop_front();
        check("mem_wr", 32'(mem_wr), 32'(me.wr));
        check("mem_addr", 32'(mem_addr), 32'(me.addr));
        if (me.wr) check("mem_din", 32'(mem_din), 32'(me.din));
        check("mem_cycle", 32'(cyc), 32'(me.cyc));
      end
    end
    if (vid_ack) begin
      if (ack_q.size() == 0) begin
        check("vid_ack_unexpected", 32'(vid_ack), 32'h0);
      end else begin
        ae = ack_q.pop_front();
        check("vid_data", 32'(vid_data), 32'(ae.data));
        check("ack_cycle", 32'(cyc), 32'(ae.cyc));
      end
    end
  end

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram[i]  = 8'h00;
      wram[i] = 8'h00;
    end
    ram[12'h905]  = 8'hA5;
    ram[12'hAFF]  = 8'h11;
    wram[12'h0FF] = 8'h9E;
    mem_dout   = 8'h00;
    w_mem_dout = 8'h00;

    reset = 1'b1;
    ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_index = 8'h00;
    ioctl_addr = '0; ioctl_dout = 8'h00; vid_rd = 1'b0; vid_addr = '0;
    idle(3);
    @(negedge clk_sys);
    check_reset_outputs("por");
    tick();
    reset = 1'b0;
    idle(3);

    // Basic video read: RAM[0x905] via offset 0x005.
    tick();
    k = cyc;
    vid_rd = 1'b1; vid_addr = 10'h005;
    push_mem(1'b0, 12'h905, 8'h00, k + 1);
    push_ack(8'hA5, k + 3);
    tick();
    vid_rd = 1'b0;
    @(negedge clk_sys);
    check("busy_during_read", 32'(busy), 32'h1);
    idle(6);

    // Downloads: ROM index (upper address bits ignored), cartridge index, cart into VRAM.
    ioctl_download = 1'b1;
    dl_write(8'h00, 25'h1000123, 8'h5A, 12'h123);
    dl_write(8'h01, 25'h0000010, 8'h3C, 12'h410);
    dl_write(8'h02, 25'h000050F, 8'hC7, 12'h90F);

    // Video read during download: zero byte in cycle 2, no RAM access.
    tick();
    k = cyc;
    vid_rd = 1'b1; vid_addr = 10'h005;
    push_ack(8'h00, k + 2);
    tick();
    vid_rd = 1'b0;
    @(negedge clk_sys);
    check("busy_zero_ack", 32'(busy), 32'h0);
    idle(4);

    // Simultaneous vid_rd and ioctl_wr: write wins, zero ack follows.
    tick();
    k = cyc;
    vid_rd = 1'b1; vid_addr = 10'h005;
    ioctl_wr = 1'b1; ioctl_index = 8'h00; ioctl_addr = 25'h00000AB; ioctl_dout = 8'hE1;
    push_mem(1'b1, 12'h0AB, 8'hE1, k + 1);
    push_ack(8'h00, k + 2);
    tick();
    vid_rd = 1'b0; ioctl_wr = 1'b0;
    idle(4);
    ioctl_download = 1'b0;
    idle(2);

    // Read back the byte the cartridge download placed at 0x90F.
    tick();
    k = cyc;
    vid_rd = 1'b1; vid_addr = 10'h00F;
    push_mem(1'b0, 12'h90F, 8'h00, k + 1);
    push_ack(8'hC7, k + 3);
    tick();
    vid_rd = 1'b0;
    idle(5);
    check("ovr_cnt_before_overrun", 32'(ovr_cnt), 32'h0);

    // Overrun: second request one cycle later is dropped.
    tick();
    k = cyc;
    vid_rd = 1'b1; vid_addr = 10'h005;
    push_mem(1'b0, 12'h905, 8'h00, k + 1);
    push_ack(8'hA5, k + 3);
    tick();
    vid_addr = 10'h00F;
    tick();
    vid_rd = 1'b0;
    idle(5);
    check("ovr_cnt_after_overrun", 32'(ovr_cnt), 32'(OVR_EXP));

    // Write during VID_WAIT is held and issued the cycle after the ack;
    // download falls again while the read is still in flight.
    tick();
    k = cyc;
    vid_rd = 1'b1; vid_addr = 10'h005;
    push_mem(1'b0, 12'h905, 8'h00, k + 1);
    push_ack(8'hA5, k + 3);
    tick();
    vid_rd = 1'b0;
    tick();
    ioctl_download = 1'b1; ioctl_wr = 1'b1; ioctl_index = 8'h00;
    ioctl_addr = 25'h0000020; ioctl_dout = 8'h77;
    push_mem(1'b1, 12'h020, 8'h77, k + 4);
    tick();
    ioctl_wr = 1'b0; ioctl_download = 1'b0;
    idle(6);

    // Wrap instance: 0xF00 + 0x1FF wraps to 0x0FF; main instance reads 0xAFF.
    tick();
    k = cyc;
    vid_rd = 1'b1; vid_addr = 10'h1FF;
    push_mem(1'b0, 12'hAFF, 8'h00, k + 1);
    push_ack(8'h11, k + 3);
    tick();
    vid_rd = 1'b0;
    @(negedge clk_sys);
    check("wrap_mem_ce", 32'(w_mem_ce), 32'h1);
    check("wrap_mem_addr", 32'(w_mem_addr), 32'h0FF);
    tick();
    tick();
    @(negedge clk_sys);
    check("wrap_vid_ack", 32'(w_vid_ack), 32'h1);
    check("wrap_vid_data", 32'(w_vid_data), 32'h9E);
    idle(4);

    // Reset in the middle of VID_WAIT: read aborted, no ack afterwards.
    tick();
    k = cyc;
    vid_rd = 1'b1; vid_addr = 10'h005;
    push_mem(1'b0, 12'h905, 8'h00, k + 1);
    tick();
    vid_rd = 1'b0;
    tick();
    reset = 1'b1;
    idle(2);
    @(negedge clk_sys);
    check_reset_outputs("mid_reset");
    tick();
    reset = 1'b0;
    idle(10);
    check("ack_after_reset_queue", 32'(ack_q.size()), 32'h0);

    idle(2);
    check("mem_queue_drained", 32'(mem_q.size()), 32'h0);
    check("ack_queue_drained", 32'(ack_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
    $finish;
  end

endmodule
